// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART RX controller and its neighbours: the
// synchronized serial line and frame configuration coming in, the checker
// results coming back, and the sampler/checker/deserializer enables going out.
//
// Handshake semantics: there is no backpressure anywhere on this bundle. Every
// enable (strt_chk_en, deser_en, par_chk_en, stp_chk_en) and data_valid is a
// single-cycle pulse that the consumer must act on in the cycle it is high.
// The checker result flags (strt_glitch, par_err, stp_err) are registered by
// their checkers and are only looked at in the last oversample of the bit whose
// check enable fired in the cycle before.
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6
);
  // line and configuration
  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] Prescale;
  // checker results
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  // controller outputs
  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  deser_en;
  logic                  data_valid;

  // controller side
  modport master (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid
  );

  // environment side: line synchronizer, checkers, deserializer
  modport slave (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive controller: detects the start condition, runs the oversample
// edge counter and the frame bit counter, fires one-cycle checker/shift
// enables at the check point of each bit, and qualifies each frame with a
// single data_valid pulse in the last cycle of the stop bit.
module uart_rx_fsm #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_fsm_if.master  bus,
  output logic [2:0]     dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO  = PRESCALE_W'(2);
  localparam logic [3:0]            LAST_DATA_BIT = 4'(DATA_W);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic                  frame_err_q, frame_err_d;
  logic                  par_en_q, par_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  // Check point and bit end are decoded against the prescale captured at
  // start detection, so live changes to Prescale cannot disturb a frame.
  logic                  bit_end;
  logic                  check_pt;

  assign bit_end  = (edge_q == (prescale_q - ONE));
  assign check_pt = (edge_q == (prescale_q - TWO));

  assign bus.edge_cnt = edge_q;
  assign bus.bit_cnt  = bit_q;
  assign dbg_state_o  = state_q;

  // State, counters and captured frame configuration.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      bit_q       <= '0;
      frame_err_q <= 1'b0;
      par_en_q    <= 1'b0;
      prescale_q  <= '0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      bit_q       <= bit_d;
      frame_err_q <= frame_err_d;
      par_en_q    <= par_en_d;
      prescale_q  <= prescale_d;
    end
  end

  // Next state, counter advance and the per-state enable/valid decode.
  always_comb begin
    state_d         = state_q;
    edge_d          = edge_q;
    bit_d           = bit_q;
    frame_err_d     = frame_err_q;
    par_en_d        = par_en_q;
    prescale_d      = prescale_q;
    bus.dat_samp_en = (state_q != IDLE);
    bus.strt_chk_en = 1'b0;
    bus.deser_en    = 1'b0;
    bus.par_chk_en  = 1'b0;
    bus.stp_chk_en  = 1'b0;
    bus.data_valid  = 1'b0;

    // Common edge/bit counting for every active state; transitions below
    // override the bit counter where a frame ends or aborts.
    if (state_q != IDLE) begin
      if (bit_end) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + ONE;
      end
    end

    case (state_q)
      IDLE: begin
        edge_d      = '0;
        bit_d       = '0;
        frame_err_d = 1'b0;
        if (!bus.RX_IN) begin
          state_d    = START;
          prescale_d = bus.Prescale;
          par_en_d   = bus.PAR_EN;
        end
      end
      START: begin
        bus.strt_chk_en = check_pt;
        if (bit_end) begin
          if (bus.strt_glitch) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        bus.deser_en = check_pt;
        if (bit_end && (bit_q == LAST_DATA_BIT)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        bus.par_chk_en = check_pt;
        if (bit_end) begin
          // A parity error only disqualifies the byte; the frame still runs
          // through its stop bit so framing stays aligned.
          frame_err_d = frame_err_q | bus.par_err;
          state_d     = STOP;
        end
      end
      STOP: begin
        bus.stp_chk_en = check_pt;
        if (bit_end) begin
          bus.data_valid = !bus.stp_err && !frame_err_q;
          state_d        = IDLE;
          bit_d          = '0;
          frame_err_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a driver plays whole serial frames with chosen
// checker outcomes, a frame model pushes every expected enable/valid pulse
// (kind, bit index, oversample index, absolute cycle) into a queue, and a
// monitor pops and compares whenever the DUT shows any pulse.
module tb_uart_rx_fsm;

  localparam int PW = 6;
  localparam int DW = 8;
  localparam int EW = 33; // kind(3) bit(4) edge(6) cycle(20)

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();
  logic [2:0] dbg_state;

  uart_rx_fsm #(.PRESCALE_W(PW), .DATA_W(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [EW-1:0] ev(input int kind, input int bitn, input int edge_i,
                                        input int unsigned c);
    return {3'(kind), 4'(bitn), 6'(edge_i), c[19:0]};
  endfunction

  function automatic logic [PW-1:0] pick_p();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Frame model: bit b occupies cycles D+b*p+1 .. D+(b+1)*p. Its check enable
  // lands one cycle before the bit's last cycle, data_valid on the last cycle
  // of the stop bit when no checker complained. Only events whose offset from
  // D is below 'limit' are expected (a reset cuts the rest off).
  task automatic push_frame(input int unsigned d, input int p, input bit pe, input bit glitch,
                            input bit perr, input bit serr, input int limit);
    int nb;
    int kind;
    nb = glitch ? 1 : (DW + 2 + int'(pe));
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                 kind = 1;
      else if (b <= DW)           kind = 2;
      else if (pe && b == DW + 1) kind = 3;
      else                        kind = 4;
      if ((b + 1) * p - 1 < limit) exp_q.push_back(ev(kind, b, p - 2, d + (b + 1) * p - 1));
    end
    if (!glitch && !(pe && perr) && !serr && (nb * p < limit))
      exp_q.push_back(ev(5, nb - 1, p - 1, d + nb * p));
  endtask

  // monitor: any pulse must match the head of the expected queue
  always @(negedge CLK) begin
    logic [4:0]    act;
    logic [EW-1:0] got;
    int            kind;
    act = {bus.data_valid, bus.stp_chk_en, bus.par_chk_en, bus.deser_en, bus.strt_chk_en};
    if (act != 5'd0) begin
      check("single_pulse", 64'($onehot(act)), 64'd1);
      if (act[0])      kind = 1;
      else if (act[1]) kind = 2;
      else if (act[2]) kind = 3;
      else if (act[3]) kind = 4;
      else             kind = 5;
      got = ev(kind, int'(bus.bit_cnt), int'(bus.edge_cnt), cyc);
      if (exp_q.size() == 0) check("unexpected_pulse", 64'(got), 64'd0);
      else                   check("pulse", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  task automatic noise_cfg();
    bus.Prescale = pick_p();
    bus.PAR_EN   = 1'($urandom_range(0, 1));
  endtask

  // driver: gap idle cycles, detection cycle, then the frame body.
  // abort_k > 0 pulls reset in frame cycle abort_k.
  task automatic send_frame(input int p, input bit pe, input logic [DW-1:0] data,
                            input bit glitch, input bit perr, input bit serr,
                            input int gap, input int abort_k);
    int unsigned d;
    int len;
    int b;
    bit aborted;
    repeat (gap) begin
      @(posedge CLK); #1;
      bus.RX_IN = 1'b1;
      noise_cfg();
    end
    @(posedge CLK); #1;
    d = cyc;
    check("idle_before_start", 64'({dbg_state, bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt}), 64'd0);
    bus.RX_IN    = 1'b0;
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pe;
    len = glitch ? p : (DW + 2 + int'(pe)) * p;
    push_frame(d, p, pe, glitch, perr, serr, (abort_k > 0) ? abort_k : len + 1);
    aborted = 1'b0;
    for (int k = 1; k <= len && !aborted; k++) begin
      @(posedge CLK); #1;
      if (k == 1) check("busy_after_detect", 64'(bus.dat_samp_en), 64'd1);
      if (k == abort_k) begin
        check("counters_before_reset", 64'({bus.bit_cnt, bus.edge_cnt}),
              64'({4'((k - 1) / p), 6'((k - 1) % p)}));
        bus.RX_IN = 1'b1;
        #1 RST = 1'b0;
        #1;
        check("outputs_in_reset", 64'({dbg_state, bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt,
              bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid}), 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        aborted = 1'b1;
      end else begin
        b = (k - 1) / p;
        if (glitch)                bus.RX_IN = 1'b1;
        else if (b == 0)           bus.RX_IN = 1'b0;
        else if (b <= DW)          bus.RX_IN = data[b - 1];
        else if (pe && b == DW + 1) bus.RX_IN = ^data;
        else                       bus.RX_IN = 1'b1;
        noise_cfg();
        bus.strt_glitch = (k == p) ? glitch : 1'($urandom_range(0, 1));
        bus.par_err     = (pe && k == (DW + 2) * p) ? perr : 1'($urandom_range(0, 1));
        bus.stp_err     = (!glitch && k == len) ? serr : 1'($urandom_range(0, 1));
      end
    end
    if (!aborted) begin
      // hand the line back high unless the next frame starts right away
      bus.RX_IN = bus.RX_IN;
    end
  endtask

  initial begin
    int p;
    bit pe, gl, pr, sr;
    bus.RX_IN       = 1'b1;
    bus.PAR_EN      = 1'b0;
    bus.Prescale    = 6'd8;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
    #3;
    check("reset_outputs", 64'({dbg_state, bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt,
          bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid}), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // directed frames
    send_frame(8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 2, 0); // clean, no parity
    send_frame(16, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 0, 0); // parity error
    send_frame(8,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 0); // start glitch
    send_frame(32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 0, 0); // stop error
    send_frame(32, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 0, 0); // clean after error
    send_frame(8,  1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 4 * 8 + 3); // reset in bit 4
    send_frame(8,  1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1, 0); // clean after reset
    send_frame(8,  1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 0, 0); // config noise mid-frame
    send_frame(16, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 0, 0); // next frame at 16

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      p  = int'(pick_p());
      pe = 1'($urandom_range(0, 1));
      gl = ($urandom_range(0, 5) == 0);
      pr = ($urandom_range(0, 3) == 0);
      sr = ($urandom_range(0, 3) == 0);
      send_frame(p, pe, 8'($urandom), gl, pr, sr, $urandom_range(0, 3), 0);
    end

    @(posedge CLK); #1;
    bus.RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_at_end", 64'({dbg_state, bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt}), 64'd0);
    check("pending_pulses", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
